tnoc_vc_packet_scheduler: RTL and testbench

//  Shares one router output link between CHANNELS virtual channels at packet granularity.

---
 rtl/tnoc_vc_packet_scheduler_if.sv | 26 ++
 rtl/tnoc_vc_packet_scheduler.sv | 152 +++++++++++++++
 tb/tb_tnoc_vc_packet_scheduler.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tnoc_vc_packet_scheduler_if.sv
// Handshake bundle between the per-VC flit sources, the scheduler and the downstream credit path.
interface tnoc_vc_packet_scheduler_if #(
  parameter int unsigned CHANNELS = 2
);
  logic [CHANNELS-1:0] i_valid;
  logic [CHANNELS-1:0] i_tail;
  logic [CHANNELS-1:0] o_ready;
  logic [CHANNELS-1:0] o_vc_grant;
  logic                o_valid;
  logic [CHANNELS-1:0] i_credit_return;
  logic [CHANNELS-1:0] o_credit_avail;
  logic                o_busy;
  logic                o_credit_error;

  // Flit sources and credit return side
  modport master (
    output i_valid, i_tail, i_credit_return,
    input  o_ready, o_vc_grant, o_valid, o_credit_avail, o_busy, o_credit_error
  );

  // Scheduler side
  modport slave (
    input  i_valid, i_tail, i_credit_return,
    output o_ready, o_vc_grant, o_valid, o_credit_avail, o_busy, o_credit_error
  );
endinterface

// File: rtl/tnoc_vc_packet_scheduler.sv
// Packet-granular round-robin VC scheduler with per-VC downstream credit tracking.
// Grant is combinational from registered state; a grant is held from head to tail flit.
module tnoc_vc_packet_scheduler #(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned CREDIT_DEPTH = 4
) (
  input logic                       clk,
  input logic                       rst,
  tnoc_vc_packet_scheduler_if.slave bus
);

  localparam int unsigned CREDIT_WIDTH = $clog2(CREDIT_DEPTH + 1);
  localparam int unsigned PTR_WIDTH    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [PTR_WIDTH-1:0]    ptr_q, ptr_d;
  logic [PTR_WIDTH-1:0]    lock_q, lock_d;
  logic [CREDIT_WIDTH-1:0] credit_q [CHANNELS];
  logic [CREDIT_WIDTH-1:0] credit_d [CHANNELS];
  logic                    error_q, error_d;

  logic [CHANNELS-1:0]     credit_avail;
  logic [CHANNELS-1:0]     req;
  logic [CHANNELS-1:0]     grant_rr;
  logic [PTR_WIDTH-1:0]    sel_vc;
  logic                    found;
  logic [CHANNELS-1:0]     grant_c;
  logic [CHANNELS-1:0]     ready_c;
  logic [CHANNELS-1:0]     xfer;

  // Next VC after v, wrapping modulo CHANNELS
  function automatic logic [PTR_WIDTH-1:0] next_vc(input logic [PTR_WIDTH-1:0] v);
    if (32'(v) + 32'd1 >= 32'(CHANNELS)) return '0;
    return v + PTR_WIDTH'(1);
  endfunction

  // Per-VC credit availability and arbitration requests
  always_comb begin
    credit_avail = '0;
    req          = '0;
    for (int v = 0; v < int'(CHANNELS); v++) begin
      credit_avail[v] = (credit_q[v] != '0);
      req[v]          = bus.i_valid[v] & credit_avail[v];
    end
  end

  // Round-robin pick: first requester scanning upward from ptr
  always_comb begin
    int idx;
    grant_rr = '0;
    sel_vc   = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      idx = (int'(ptr_q) + i) % int'(CHANNELS);
      if (!found && req[idx]) begin
        found         = 1'b1;
        grant_rr[idx] = 1'b1;
        sel_vc        = PTR_WIDTH'(idx);
      end
    end
  end

  // FSM next state, grant and ready; nothing is granted while rst is high
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    grant_c = '0;
    ready_c = '0;
    case (state_q)
      IDLE: begin
        grant_c = grant_rr;
        ready_c = grant_rr;
        if (found && !rst) begin
          if (bus.i_tail[sel_vc]) begin
            ptr_d = next_vc(sel_vc);
          end else begin
            state_d = LOCKED;
            lock_d  = sel_vc;
          end
        end
      end
      LOCKED: begin
        grant_c[lock_q] = 1'b1;
        ready_c[lock_q] = credit_avail[lock_q];
        if (!rst && bus.i_valid[lock_q] && credit_avail[lock_q] && bus.i_tail[lock_q]) begin
          state_d = IDLE;
          ptr_d   = next_vc(lock_q);
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      grant_c = '0;
      ready_c = '0;
    end
  end

  assign xfer = bus.i_valid & ready_c;

  // Credit counters: consume on transfer, refill on return, flag overflow returns
  always_comb begin
    error_d = error_q;
    for (int v = 0; v < int'(CHANNELS); v++) begin
      credit_d[v] = credit_q[v];
      if (xfer[v] && !bus.i_credit_return[v]) begin
        credit_d[v] = credit_q[v] - CREDIT_WIDTH'(1);
      end else if (bus.i_credit_return[v] && !xfer[v] &&
                   credit_q[v] != CREDIT_WIDTH'(CREDIT_DEPTH)) begin
        credit_d[v] = credit_q[v] + CREDIT_WIDTH'(1);
      end
      if (bus.i_credit_return[v] && credit_q[v] == CREDIT_WIDTH'(CREDIT_DEPTH)) begin
        error_d = 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      lock_q  <= '0;
      error_q <= 1'b0;
      for (int v = 0; v < int'(CHANNELS); v++) begin
        credit_q[v] <= CREDIT_WIDTH'(CREDIT_DEPTH);
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      error_q <= error_d;
      for (int v = 0; v < int'(CHANNELS); v++) begin
        credit_q[v] <= credit_d[v];
      end
    end
  end

  assign bus.o_ready        = ready_c;
  assign bus.o_vc_grant     = grant_c;
  assign bus.o_valid        = |xfer;
  assign bus.o_credit_avail = rst ? '0 : credit_avail;
  assign bus.o_busy         = !rst && (state_q == LOCKED);
  assign bus.o_credit_error = !rst && error_q;

endmodule

// File: tb/tb_tnoc_vc_packet_scheduler.sv
// Directed bench for the VC packet scheduler (CHANNELS=2, CREDIT_DEPTH=4).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_tnoc_vc_packet_scheduler;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  tnoc_vc_packet_scheduler_if #(.CHANNELS(2)) bus ();

  tnoc_vc_packet_scheduler #(
    .CHANNELS     (2),
    .CREDIT_DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view of the handshake outputs: {ready[1:0], grant[1:0], valid, busy}
  function automatic logic [5:0] obs();
    return {bus.o_ready, bus.o_vc_grant, bus.o_valid, bus.o_busy};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_valid = 2'b11;
    bus.i_tail = 2'b11;
    bus.i_credit_return = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (obs() !== 6'b00_00_0_0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected %b", obs(), 6'b00_00_0_0);
    end
    n_checks++;
    if (bus.o_credit_avail !== 2'b00 || bus.o_credit_error !== 1'b0) begin
      n_fail++; $display("FAIL reset_credit: got avail=%b err=%b expected avail=00 err=0",
                         bus.o_credit_avail, bus.o_credit_error);
    end
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (bus.o_credit_avail !== 2'b11) begin
      n_fail++; $display("FAIL post_reset_avail: got %b expected 11", bus.o_credit_avail);
    end
    n_checks++;
    if (obs() !== 6'b01_01_1_0) begin
      n_fail++; $display("FAIL post_reset_grant: got %b expected %b", obs(), 6'b01_01_1_0);
    end
    bus.i_valid = 2'b00;
    step();
  endtask

  task automatic test_round_robin();
    logic [1:0] g;
    bus.i_valid = 2'b11;
    bus.i_tail  = 2'b11;
    for (int i = 0; i < 4; i++) begin
      g = (i % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      n_checks++;
      if (obs() !== {g, g, 1'b1, 1'b0}) begin
        n_fail++; $display("FAIL rr_cycle%0d: got %b expected %b", i, obs(), {g, g, 1'b1, 1'b0});
      end
      step();
    end
    bus.i_valid = 2'b00;
    bus.i_credit_return = 2'b11;
    step();
    step();
    bus.i_credit_return = 2'b00;
  endtask

  task automatic test_lock();
    logic [5:0] exp [4];
    logic [1:0] t0 [4];
    exp[0] = 6'b01_01_1_0; t0[0] = 2'b10;
    exp[1] = 6'b01_01_1_1; t0[1] = 2'b10;
    exp[2] = 6'b01_01_1_1; t0[2] = 2'b11;
    exp[3] = 6'b10_10_1_0; t0[3] = 2'b11;
    bus.i_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      bus.i_tail = t0[i];
      @(negedge clk);
      n_checks++;
      if (obs() !== exp[i]) begin
        n_fail++; $display("FAIL lock_cycle%0d: got %b expected %b", i, obs(), exp[i]);
      end
      step();
    end
    bus.i_valid = 2'b00;
    bus.i_credit_return = 2'b11;
    step();
    bus.i_credit_return = 2'b01;
    step();
    step();
    bus.i_credit_return = 2'b00;
  endtask

  task automatic test_credit_stall();
    logic [5:0] exp [9];
    logic [1:0] val [9];
    logic [1:0] tl  [9];
    logic [1:0] rt  [9];
    exp[0] = 6'b01_01_1_0; val[0] = 2'b01; tl[0] = 2'b00; rt[0] = 2'b00;
    exp[1] = 6'b01_01_1_1; val[1] = 2'b01; tl[1] = 2'b00; rt[1] = 2'b00;
    exp[2] = 6'b01_01_1_1; val[2] = 2'b01; tl[2] = 2'b00; rt[2] = 2'b00;
    exp[3] = 6'b01_01_1_1; val[3] = 2'b01; tl[3] = 2'b00; rt[3] = 2'b00;
    exp[4] = 6'b00_01_0_1; val[4] = 2'b11; tl[4] = 2'b10; rt[4] = 2'b00;
    exp[5] = 6'b00_01_0_1; val[5] = 2'b11; tl[5] = 2'b10; rt[5] = 2'b01;
    exp[6] = 6'b01_01_1_1; val[6] = 2'b01; tl[6] = 2'b00; rt[6] = 2'b00;
    exp[7] = 6'b00_01_0_1; val[7] = 2'b01; tl[7] = 2'b00; rt[7] = 2'b01;
    exp[8] = 6'b01_01_1_1; val[8] = 2'b01; tl[8] = 2'b01; rt[8] = 2'b00;
    for (int i = 0; i < 9; i++) begin
      bus.i_valid = val[i];
      bus.i_tail = tl[i];
      bus.i_credit_return = rt[i];
      @(negedge clk);
      n_checks++;
      if (obs() !== exp[i]) begin
        n_fail++; $display("FAIL stall_cycle%0d: got %b expected %b", i, obs(), exp[i]);
      end
      if (i == 4) begin
        n_checks++;
        if (bus.o_credit_avail !== 2'b10) begin
          n_fail++; $display("FAIL stall_avail: got %b expected 10", bus.o_credit_avail);
        end
      end
      step();
    end
    bus.i_valid = 2'b00;
    bus.i_credit_return = 2'b00;
    @(negedge clk);
    n_checks++;
    if (obs() !== 6'b00_00_0_0) begin
      n_fail++; $display("FAIL stall_release_idle: got %b expected %b", obs(), 6'b00_00_0_0);
    end
    step();
    bus.i_credit_return = 2'b01;
    repeat (4) step();
    bus.i_credit_return = 2'b00;
  endtask

  task automatic test_simultaneous();
    bus.i_valid = 2'b10;
    bus.i_tail  = 2'b10;
    for (int i = 0; i < 5; i++) begin
      bus.i_credit_return = (i == 1) ? 2'b10 : 2'b00;
      @(negedge clk);
      n_checks++;
      if (obs() !== 6'b10_10_1_0) begin
        n_fail++; $display("FAIL simul_xfer%0d: got %b expected %b", i, obs(), 6'b10_10_1_0);
      end
      step();
    end
    bus.i_credit_return = 2'b00;
    @(negedge clk);
    n_checks++;
    if (obs() !== 6'b00_00_0_0 || bus.o_credit_avail !== 2'b01) begin
      n_fail++; $display("FAIL simul_exhausted: got obs=%b avail=%b expected obs=000000 avail=01",
                         obs(), bus.o_credit_avail);
    end
    step();
    bus.i_valid = 2'b00;
    bus.i_credit_return = 2'b10;
    repeat (4) step();
    bus.i_credit_return = 2'b00;
    @(negedge clk);
    n_checks++;
    if (bus.o_credit_error !== 1'b0) begin
      n_fail++; $display("FAIL error_before_overflow: got %b expected 0", bus.o_credit_error);
    end
    step();
    bus.i_credit_return = 2'b10;
    step();
    bus.i_credit_return = 2'b00;
    @(negedge clk);
    n_checks++;
    if (bus.o_credit_error !== 1'b1 || bus.o_credit_avail !== 2'b11) begin
      n_fail++; $display("FAIL overflow_flag: got err=%b avail=%b expected err=1 avail=11",
                         bus.o_credit_error, bus.o_credit_avail);
    end
    step();
    bus.i_valid = 2'b10;
    bus.i_tail  = 2'b10;
    repeat (4) step();
    bus.i_valid = 2'b00;
    @(negedge clk);
    n_checks++;
    if (bus.o_credit_avail !== 2'b01 || bus.o_credit_error !== 1'b1) begin
      n_fail++; $display("FAIL overflow_hold: got avail=%b err=%b expected avail=01 err=1",
                         bus.o_credit_avail, bus.o_credit_error);
    end
    step();
    bus.i_credit_return = 2'b10;
    repeat (4) step();
    bus.i_credit_return = 2'b00;
  endtask

  task automatic test_reset_mid_packet();
    bus.i_valid = 2'b10;
    bus.i_tail  = 2'b00;
    @(negedge clk);
    n_checks++;
    if (obs() !== 6'b10_10_1_0) begin
      n_fail++; $display("FAIL mid_head: got %b expected %b", obs(), 6'b10_10_1_0);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (obs() !== 6'b10_10_1_1) begin
      n_fail++; $display("FAIL mid_locked: got %b expected %b", obs(), 6'b10_10_1_1);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (obs() !== 6'b00_00_0_0 || bus.o_credit_avail !== 2'b00) begin
      n_fail++; $display("FAIL mid_in_reset: got obs=%b avail=%b expected obs=000000 avail=00",
                         obs(), bus.o_credit_avail);
    end
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    bus.i_valid = 2'b11;
    bus.i_tail  = 2'b11;
    #1;
    n_checks++;
    if (obs() !== 6'b01_01_1_0) begin
      n_fail++; $display("FAIL mid_after_reset_grant: got %b expected %b", obs(), 6'b01_01_1_0);
    end
    n_checks++;
    if (bus.o_credit_avail !== 2'b11 || bus.o_credit_error !== 1'b0) begin
      n_fail++; $display("FAIL mid_after_reset_credit: got avail=%b err=%b expected avail=11 err=0",
                         bus.o_credit_avail, bus.o_credit_error);
    end
    bus.i_valid = 2'b00;
    step();
  endtask

  // Hard stop in case the sequence stalls
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.i_valid = '0;
    bus.i_tail = '0;
    bus.i_credit_return = '0;
    test_reset();
    test_round_robin();
    test_lock();
    test_credit_stall();
    test_simultaneous();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
